// File: rtl/io_memory_map.sv
// MIPS150 X-stage address decode plus memory-mapped IO: UART RX/TX FIFOs,
// cycle and instruction counters, and the DMEM/IMEM store-enable split.

module io_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [W-1:0]  mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

module io_memory_map #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [3:0]  store_mask,
   input  logic [31:0] store_data,
   input  logic        mem_read,
   input  logic        instr_valid,
   output logic [3:0]  store_mask_dmem,
   output logic [3:0]  store_mask_imem,
   output logic        load_io_sel,
   output logic [31:0] io_rdata,
   input  logic [7:0]  rx_in_data,
   input  logic        rx_in_valid,
   output logic        rx_in_ready,
   output logic [7:0]  tx_out_data,
   output logic        tx_out_valid,
   input  logic        tx_out_ready
);
   localparam logic [7:0] OFF_RX_STAT = 8'h00;
   localparam logic [7:0] OFF_RX_DATA = 8'h04;
   localparam logic [7:0] OFF_TX_STAT = 8'h08;
   localparam logic [7:0] OFF_TX_DATA = 8'h0C;
   localparam logic [7:0] OFF_CYC_CNT = 8'h10;
   localparam logic [7:0] OFF_INS_CNT = 8'h14;
   localparam logic [7:0] OFF_CNT_CLR = 8'h18;

   logic             io_sel;
   logic             is_store;
   logic             io_load;
   logic             io_store;
   logic [7:0]       off;
   logic [7:0]       rx_head;
   logic [7:0]       tx_head;
   logic             rx_full;
   logic             rx_empty;
   logic             tx_full;
   logic             tx_empty;
   logic             rx_pop;
   logic             tx_push_req;
   logic             tx_pop;
   logic             cnt_clr;
   logic             tx_overflow;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instr_cnt;
   logic             unused_bits;

   assign unused_bits = ^{addr[30], addr[27:8], store_data[31:8]};

   assign io_sel   = addr[31];
   assign off      = addr[7:0];
   assign is_store = |store_mask;
   assign io_load  = io_sel & mem_read;
   assign io_store = io_sel & is_store;

   assign store_mask_dmem = (~addr[31] & addr[28]) ? store_mask : 4'b0000;
   assign store_mask_imem = (~addr[31] & addr[29]) ? store_mask : 4'b0000;
   assign load_io_sel     = mem_read & addr[31];

   assign rx_pop      = io_load & (off == OFF_RX_DATA);
   assign tx_push_req = io_store & (off == OFF_TX_DATA);
   assign tx_pop      = ~tx_empty & tx_out_ready;
   assign cnt_clr     = io_store & (off == OFF_CNT_CLR);

   assign rx_in_ready  = ~rx_full;
   assign tx_out_valid = ~tx_empty;
   assign tx_out_data  = tx_head;

   io_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rx_in_valid),
      .push_data (rx_in_data),
      .pop       (rx_pop),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   // Fullness is judged before any same-cycle UART pop, so a push into a full FIFO drops.
   io_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tx_push_req),
      .push_data (store_data[7:0]),
      .pop       (tx_pop),
      .head      (tx_head),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_overflow <= 1'b0;
         cycle_cnt   <= '0;
         instr_cnt   <= '0;
      end else begin
         if (tx_push_req & tx_full)                    tx_overflow <= 1'b1;
         else if (io_load & (off == OFF_TX_STAT))      tx_overflow <= 1'b0;
         if (cnt_clr) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
         end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (instr_valid) instr_cnt <= instr_cnt + CNT_W'(1);
         end
      end
   end

   // Read mux reflects current state; zero unless an IO load is in X.
   always_comb begin
      io_rdata = 32'h0;
      if (io_load) begin
         case (off)
            OFF_RX_STAT: io_rdata = {31'b0, ~rx_empty};
            OFF_RX_DATA: io_rdata = {24'b0, rx_head};
            OFF_TX_STAT: io_rdata = {30'b0, tx_overflow, ~tx_full};
            OFF_CYC_CNT: io_rdata = 32'(cycle_cnt);
            OFF_INS_CNT: io_rdata = 32'(instr_cnt);
            default:     io_rdata = 32'h0;
         endcase
      end
   end
endmodule

// File: tb/tb_io_memory_map.sv
// Directed bench for io_memory_map: decode, RX/TX FIFOs, overflow, counters, reset.

module tb_io_memory_map;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [3:0]  store_mask;
   logic [31:0] store_data;
   logic        mem_read;
   logic        instr_valid;
   logic [3:0]  store_mask_dmem;
   logic [3:0]  store_mask_imem;
   logic        load_io_sel;
   logic [31:0] io_rdata;
   logic [7:0]  rx_in_data;
   logic        rx_in_valid;
   logic        rx_in_ready;
   logic [7:0]  tx_out_data;
   logic        tx_out_valid;
   logic        tx_out_ready;

   int errors = 0;
   int checks = 0;

   io_memory_map dut (
      .clk             (clk),
      .rst             (rst),
      .addr            (addr),
      .store_mask      (store_mask),
      .store_data      (store_data),
      .mem_read        (mem_read),
      .instr_valid     (instr_valid),
      .store_mask_dmem (store_mask_dmem),
      .store_mask_imem (store_mask_imem),
      .load_io_sel     (load_io_sel),
      .io_rdata        (io_rdata),
      .rx_in_data      (rx_in_data),
      .rx_in_valid     (rx_in_valid),
      .rx_in_ready     (rx_in_ready),
      .tx_out_data     (tx_out_data),
      .tx_out_valid    (tx_out_valid),
      .tx_out_ready    (tx_out_ready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic io_load(input logic [31:0] a);
      addr       = a;
      mem_read   = 1'b1;
      store_mask = 4'b0000;
      #1;
   endtask

   initial begin
      rst = 1'b1; addr = '0; store_mask = '0; store_data = '0; mem_read = 1'b0;
      instr_valid = 1'b0; rx_in_data = '0; rx_in_valid = 1'b0; tx_out_ready = 1'b0;
      step();
      chk("rst_rx_ready", 32'(rx_in_ready), 32'd1);
      chk("rst_tx_valid", 32'(tx_out_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_out_data), 32'd0);

      // Decode is combinational, so exercise it while reset holds the state still.
      addr = 32'h1000_0004; store_mask = 4'b1111; #1;
      chk("dec_dmem_a", 32'(store_mask_dmem), 32'hF);
      chk("dec_imem_a", 32'(store_mask_imem), 32'h0);
      addr = 32'h3000_0008; store_mask = 4'b0011; #1;
      chk("dec_dmem_b", 32'(store_mask_dmem), 32'h3);
      chk("dec_imem_b", 32'(store_mask_imem), 32'h3);
      addr = 32'h8000_000C; store_mask = 4'b1111; #1;
      chk("dec_dmem_io", 32'(store_mask_dmem), 32'h0);
      chk("dec_imem_io", 32'(store_mask_imem), 32'h0);
      store_mask = 4'b0000; mem_read = 1'b1; addr = 32'h8000_0000; #1;
      chk("load_io_sel_io", 32'(load_io_sel), 32'd1);
      addr = 32'h1000_0000; #1;
      chk("load_io_sel_mem", 32'(load_io_sel), 32'd0);
      mem_read = 1'b0; addr = 32'h8000_0008; #1;
      chk("rdata_no_read", io_rdata, 32'h0);
      step();
      rst = 1'b0;

      // RX basic path
      rx_in_valid = 1'b1; rx_in_data = 8'h41; step();
      rx_in_data = 8'h42; step();
      rx_in_valid = 1'b0;
      io_load(32'h8000_0000);
      chk("rx_stat_ne", io_rdata, 32'h1);
      io_load(32'h8000_0004);
      chk("rx_pop1", io_rdata, 32'h41);
      step();
      chk("rx_pop2", io_rdata, 32'h42);
      step();
      chk("rx_pop_empty", io_rdata, 32'h0);
      step();
      io_load(32'h8000_0000);
      chk("rx_stat_empty", io_rdata, 32'h0);
      mem_read = 1'b0;

      // RX full and hold-off
      rx_in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rx_in_data = 8'(8'h10 + i);
         step();
      end
      chk("rx_full_ready", 32'(rx_in_ready), 32'd0);
      rx_in_data = 8'h99; step();
      chk("rx_ninth_held", 32'(rx_in_ready), 32'd0);
      io_load(32'h8000_0004);
      chk("rx_full_head", io_rdata, 32'h10);
      chk("rx_ready_no_pop_fwd", 32'(rx_in_ready), 32'd0);
      step();
      mem_read = 1'b0; #1;
      chk("rx_ready_after_pop", 32'(rx_in_ready), 32'd1);
      step();
      rx_in_valid = 1'b0; #1;
      chk("rx_ninth_filled", 32'(rx_in_ready), 32'd0);
      io_load(32'h8000_0004);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("rx_drain%0d", i), io_rdata, (i < 7) ? 32'(32'h11 + i) : 32'h99);
         step();
      end
      io_load(32'h8000_0000);
      chk("rx_drained_stat", io_rdata, 32'h0);
      mem_read = 1'b0;

      // TX overflow
      tx_out_ready = 1'b0;
      addr = 32'h8000_000C; store_mask = 4'b0001;
      for (int i = 0; i < 9; i++) begin
         store_data = 32'(32'hFFFF_FFA0 + i);
         step();
         if (i == 0) begin
            chk("tx_valid_next", 32'(tx_out_valid), 32'd1);
            chk("tx_head_first", 32'(tx_out_data), 32'hA0);
         end
      end
      store_mask = 4'b0000;
      io_load(32'h8000_0008);
      chk("tx_stat_ovf", io_rdata, 32'h2);
      step();
      chk("tx_stat_cleared", io_rdata, 32'h0);
      mem_read = 1'b0;
      tx_out_ready = 1'b1; #1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("tx_valid%0d", i), 32'(tx_out_valid), 32'd1);
         chk($sformatf("tx_data%0d", i), 32'(tx_out_data), 32'(32'hA0 + i));
         step();
      end
      chk("tx_drained", 32'(tx_out_valid), 32'd0);
      io_load(32'h8000_0008);
      chk("tx_stat_notfull", io_rdata, 32'h1);
      mem_read = 1'b0; tx_out_ready = 1'b0;

      // Reset with three bytes in each FIFO
      rx_in_valid = 1'b1; addr = 32'h8000_000C; store_mask = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         rx_in_data = 8'(8'h60 + i);
         store_data = 32'(32'h70 + i);
         step();
      end
      rx_in_valid = 1'b0; store_mask = 4'b0000;
      io_load(32'h8000_0000);
      chk("pre_rst_rx_stat", io_rdata, 32'h1);
      chk("pre_rst_tx_valid", 32'(tx_out_valid), 32'd1);
      mem_read = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0; #1;
      chk("mid_rst_tx_valid", 32'(tx_out_valid), 32'd0);
      chk("mid_rst_rx_ready", 32'(rx_in_ready), 32'd1);
      io_load(32'h8000_0000);
      chk("mid_rst_rx_stat", io_rdata, 32'h0);
      mem_read = 1'b0;

      // Counters: 100 edges since the reset edge, instr_valid on odd-numbered cycles
      for (int i = 1; i <= 100; i++) begin
         instr_valid = (i % 2 == 1);
         step();
      end
      instr_valid = 1'b0;
      io_load(32'h8000_0010);
      chk("cyc_cnt_100", io_rdata, 32'd100);
      io_load(32'h8000_0014);
      chk("ins_cnt_50", io_rdata, 32'd50);
      mem_read = 1'b0; addr = 32'h8000_0018; store_mask = 4'b0100; instr_valid = 1'b1;
      step();
      store_mask = 4'b0000;
      io_load(32'h8000_0010);
      chk("cyc_cnt_clr", io_rdata, 32'd0);
      io_load(32'h8000_0014);
      chk("ins_cnt_clr", io_rdata, 32'd0);
      step(); step(); step();
      instr_valid = 1'b0;
      io_load(32'h8000_0010);
      chk("cyc_cnt_resume", io_rdata, 32'd3);
      io_load(32'h8000_0014);
      chk("ins_cnt_resume", io_rdata, 32'd3);
      mem_read = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
